// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_irq peripheral: register offsets,
// default parameter values, reset constants and the byte-lane mask helper.
package gpio_pkg;

  localparam int DB_WIDTH_DEF = 16;

  // Register byte offsets within the 64-byte window (wb_addr[5:2] decode)
  localparam logic [5:0] OFF_DATA_OUT   = 6'h00;
  localparam logic [5:0] OFF_DATA_IN    = 6'h04;
  localparam logic [5:0] OFF_DIR        = 6'h08;
  localparam logic [5:0] OFF_OUT_SET    = 6'h0C;
  localparam logic [5:0] OFF_OUT_CLR    = 6'h10;
  localparam logic [5:0] OFF_OUT_TGL    = 6'h14;
  localparam logic [5:0] OFF_IRQ_EN     = 6'h18;
  localparam logic [5:0] OFF_IRQ_RISE   = 6'h1C;
  localparam logic [5:0] OFF_IRQ_FALL   = 6'h20;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'h24;
  localparam logic [5:0] OFF_DB_DIV     = 6'h28;

  localparam logic [31:0] RST_REG = 32'h0000_0000;

  // Expand the four byte enables into a 32-bit lane mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Input conditioning for gpio_irq: synchroniser chain, shared debounce
// prescaler, per-pin two-sample filter and rise/fall pulse generation.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int NUM_GPIOS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = DB_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  input  logic [DB_WIDTH-1:0]  db_div,
  input  logic                 db_div_wr,
  output logic [NUM_GPIOS-1:0] filt,
  output logic [NUM_GPIOS-1:0] rise,
  output logic [NUM_GPIOS-1:0] fall
);

  logic [NUM_GPIOS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIOS-1:0] sync_out;
  logic [NUM_GPIOS-1:0] samp_q;
  logic [NUM_GPIOS-1:0] filt_q;
  logic [NUM_GPIOS-1:0] agree;
  logic [DB_WIDTH-1:0]  cnt_q;
  logic                 bypass;
  logic                 tick;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign bypass   = (db_div == '0);
  // With DB_DIV=0 the counter sits at 0 and ticks every cycle
  assign tick     = (cnt_q == db_div);
  assign agree    = ~(sync_out ^ samp_q);

  // Metastability synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Prescaler: counts 0..DB_DIV, restarts on wrap or on a DB_DIV write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (db_div_wr || tick) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end

  // Two-sample filter: a pin follows its input only when two tick samples agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      filt   <= '0;
    end else if (bypass) begin
      samp_q <= sync_out;
      filt   <= sync_out;
    end else if (tick) begin
      samp_q <= sync_out;
      filt   <= (filt & ~agree) | (sync_out & agree);
    end
  end

  // Previous filtered value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_q <= '0;
    else        filt_q <= filt;
  end

  assign rise = filt & ~filt_q;
  assign fall = ~filt & filt_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral with atomic set/clear/toggle, edge interrupt capture,
// shared debounce and a single level interrupt. Holds the Wishbone
// register file; input conditioning lives in gpio_debounce.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_GPIOS   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = DB_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic                  wb_stb,
  output logic                  wb_ack,
  input  logic [NUM_GPIOS-1:0]  gpio_in,
  output logic [NUM_GPIOS-1:0]  gpio_out,
  output logic [NUM_GPIOS-1:0]  gpio_oe,
  output logic                  irq
);

  logic [NUM_GPIOS-1:0] data_out, dir, irq_en, irq_rise, irq_fall, irq_status;
  logic [NUM_GPIOS-1:0] filt, rise, fall, wm, bm, stat_clr, stat_set;
  logic [DB_WIDTH-1:0]  db_div;
  logic [31:0]          bm32, wbits, rdata;
  logic [5:0]           off;
  logic                 access, wr, db_div_wr;
  logic                 unused_bits;

  assign off       = {wb_addr[5:2], 2'b00};
  assign access    = wb_stb && !wb_ack;
  assign wr        = access && wb_we;
  assign bm32      = byte_mask(wb_sel);
  assign wbits     = wb_dat_i & bm32;
  assign bm        = bm32[NUM_GPIOS-1:0];
  assign wm        = wbits[NUM_GPIOS-1:0];
  assign db_div_wr = wr && (off == OFF_DB_DIV);
  assign stat_clr  = (wr && off == OFF_IRQ_STATUS) ? wm : '0;
  assign stat_set  = (rise & irq_rise) | (fall & irq_fall);
  assign unused_bits = ^{wb_addr, wb_dat_i};

  function automatic logic [31:0] pad(input logic [NUM_GPIOS-1:0] v);
    return 32'(v);
  endfunction

  gpio_debounce #(
    .NUM_GPIOS  (NUM_GPIOS),
    .SYNC_STAGES(SYNC_STAGES),
    .DB_WIDTH   (DB_WIDTH)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .gpio_in  (gpio_in),
    .db_div   (db_div),
    .db_div_wr(db_div_wr),
    .filt     (filt),
    .rise     (rise),
    .fall     (fall)
  );

  // Read mux; unmapped offsets return 0
  always_comb begin
    rdata = RST_REG;
    case (off)
      OFF_DATA_OUT, OFF_OUT_SET,
      OFF_OUT_CLR, OFF_OUT_TGL: rdata = pad(data_out);
      OFF_DATA_IN:              rdata = pad(filt);
      OFF_DIR:                  rdata = pad(dir);
      OFF_IRQ_EN:               rdata = pad(irq_en);
      OFF_IRQ_RISE:             rdata = pad(irq_rise);
      OFF_IRQ_FALL:             rdata = pad(irq_fall);
      OFF_IRQ_STATUS:           rdata = pad(irq_status);
      OFF_DB_DIV:               rdata = 32'(db_div);
      default:                  rdata = RST_REG;
    endcase
  end

  // Bus handshake: one-cycle ack with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= RST_REG;
    end else begin
      wb_ack <= access;
      if (access) wb_dat_o <= rdata;
    end
  end

  // Register file writes with byte-lane masking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      irq_rise <= '0;
      irq_fall <= '0;
      db_div   <= '0;
    end else if (wr) begin
      case (off)
        OFF_DATA_OUT: data_out <= (data_out & ~bm) | wm;
        OFF_OUT_SET:  data_out <= data_out | wm;
        OFF_OUT_CLR:  data_out <= data_out & ~wm;
        OFF_OUT_TGL:  data_out <= data_out ^ wm;
        OFF_DIR:      dir      <= (dir & ~bm) | wm;
        OFF_IRQ_EN:   irq_en   <= (irq_en & ~bm) | wm;
        OFF_IRQ_RISE: irq_rise <= (irq_rise & ~bm) | wm;
        OFF_IRQ_FALL: irq_fall <= (irq_fall & ~bm) | wm;
        OFF_DB_DIV:   db_div   <= (db_div & ~bm32[DB_WIDTH-1:0]) | wbits[DB_WIDTH-1:0];
        default:      ;
      endcase
    end
  end

  // Interrupt status: edge capture wins over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_status <= '0;
    else        irq_status <= (irq_status & ~stat_clr) | stat_set;
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;
  assign irq      = |(irq_status & irq_en);

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios followed by
// randomized register and pad activity against a behavioural model.
module tb_gpio_irq;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wb_addr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic        wb_stb = 1'b0;
  logic        wb_ack;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int failures = 0;

  gpio_irq #(.ADDR_WIDTH(8), .NUM_GPIOS(32), .SYNC_STAGES(S), .DB_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_sel(wb_sel), .wb_stb(wb_stb),
    .wb_ack(wb_ack), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] a, input logic we, input logic [31:0] d,
                      input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_addr = a; wb_we = we; wb_dat_i = d; wb_sel = sel; wb_stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack && n < 10);
    chk("ack", {31'b0, wb_ack}, 32'd1);
    rd = wb_dat_o;
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    xfer(a, 1'b1, d, sel, dummy);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    xfer(a, 1'b0, 32'h0, 4'hF, d);
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] sel);
    logic [31:0] m = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  initial begin
    logic [31:0] r, m_out, m_dir, m_rise, m_fall, m_en, m_stat, oldp, newp, d, bm, msk;
    logic [7:0]  a;
    logic [7:0]  wtab [5];
    int n;
    wtab[0] = 8'h00; wtab[1] = 8'h0C; wtab[2] = 8'h10; wtab[3] = 8'h14; wtab[4] = 8'h08;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_ack", {31'b0, wb_ack}, 0);
    chk("rst_dat_o", wb_dat_o, 0);
    rst_n = 1'b1;
    for (int off = 0; off <= 'h28; off += 4) begin
      rd(8'(off), r);
      chk($sformatf("rst_reg_%02h", off), r, 0);
    end
    rd(8'h3C, r);
    chk("unmapped_read", r, 0);
    @(posedge clk); #1;
    chk("ack_single_cycle", {31'b0, wb_ack}, 0);

    // Atomic output operations and byte-masked write
    wr(8'h00, 32'h0000_00F0);
    chk("data_out_visible", gpio_out, 32'h0000_00F0);
    wr(8'h0C, 32'h0000_000F);
    wr(8'h10, 32'h0000_0030);
    wr(8'h14, 32'h0000_0101);
    rd(8'h00, r);
    chk("data_out_atomic", r, 32'h0000_01CE);
    rd(8'h0C, r);
    chk("out_set_reads_data", r, 32'h0000_01CE);
    wr(8'h08, 32'hFFFF_FFFF, 4'b0001);
    rd(8'h08, r);
    chk("dir_byte_mask", r, 32'h0000_00FF);
    chk("gpio_oe", gpio_oe, 32'h0000_00FF);

    // Rising edge interrupt latency with debounce bypassed
    wr(8'h1C, 32'h8);
    wr(8'h18, 32'h8);
    @(posedge clk); #1;
    gpio_in[3] = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    chk("irq_not_early", {31'b0, irq}, 0);
    @(posedge clk); #1;
    chk("irq_rise3", {31'b0, irq}, 1);
    rd(8'h24, r);
    chk("status_rise3", r, 32'h8);
    wr(8'h24, 32'h8);
    chk("irq_cleared", {31'b0, irq}, 0);

    // Falling edge captured while masked, then enabled
    wr(8'h18, 32'h0);
    wr(8'h20, 32'h20);
    @(posedge clk); #1; gpio_in[5] = 1'b1;
    repeat (6) @(posedge clk);
    #1; gpio_in[5] = 1'b0;
    repeat (6) @(posedge clk);
    rd(8'h24, r);
    chk("status_fall5", r, 32'h20);
    chk("irq_masked", {31'b0, irq}, 0);
    wr(8'h18, 32'h20);
    chk("irq_enabled", {31'b0, irq}, 1);

    // Debounce with DB_DIV=9: glitch rejected, stable level accepted
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h18, 32'h1);
    wr(8'h1C, 32'h9);
    wr(8'h28, 32'd9);
    rd(8'h28, r);
    chk("db_div", r, 32'd9);
    @(posedge clk); #1; gpio_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1; gpio_in[0] = 1'b0;
    repeat (40) @(posedge clk);
    rd(8'h04, r);
    chk("glitch_data_in", r, 32'h8);
    rd(8'h24, r);
    chk("glitch_status", r, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 0);
    @(posedge clk); #1; gpio_in[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!irq && n < 100);
    chk("db_irq", {31'b0, irq}, 1);
    chk("db_latency", {31'b0, (n >= S + 2 && n <= S + 21)}, 1);
    repeat (40) @(posedge clk);
    rd(8'h04, r);
    chk("db_data_in", r, 32'h9);

    // Edge coincident with W1C of the same bit: set wins
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h28, 32'd0);
    wr(8'h1C, 32'h4);
    repeat (4) @(posedge clk);
    #1; gpio_in[2] = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    wb_addr = 8'h24; wb_we = 1'b1; wb_dat_i = 32'h4; wb_sel = 4'hF; wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("coinc_ack", {31'b0, wb_ack}, 1);
    wb_stb = 1'b0; wb_we = 1'b0;
    rd(8'h24, r);
    chk("set_wins", r, 32'h4);

    // Asynchronous reset in the middle of a write
    @(posedge clk); #1;
    wb_addr = 8'h00; wb_we = 1'b1; wb_dat_i = 32'hFFFF_FFFF; wb_sel = 4'hF; wb_stb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, wb_ack}, 0);
    chk("midrst_gpio_out", gpio_out, 0);
    chk("midrst_gpio_oe", gpio_oe, 0);
    chk("midrst_irq", {31'b0, irq}, 0);
    wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    rd(8'h00, r);
    chk("midrst_write_lost", r, 0);

    // Random register traffic against the model
    m_out = 0; m_dir = 0;
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 4);
      a = wtab[n];
      d = $urandom;
      bm = lanes(4'($urandom_range(0, 15)));
      msk = d & bm;
      case (n)
        0: m_out = (m_out & ~bm) | msk;
        1: m_out = m_out | msk;
        2: m_out = m_out & ~msk;
        3: m_out = m_out ^ msk;
        default: m_dir = (m_dir & ~bm) | msk;
      endcase
      wr(a, d, {bm[24], bm[16], bm[8], bm[0]});
      chk($sformatf("rnd_out_%0d", i), gpio_out, m_out);
      chk($sformatf("rnd_oe_%0d", i), gpio_oe, m_dir);
    end

    // Random pad activity with random edge configuration
    m_rise = $urandom; m_fall = $urandom; m_en = $urandom; m_stat = 0;
    wr(8'h1C, m_rise);
    wr(8'h20, m_fall);
    wr(8'h18, m_en);
    oldp = gpio_in;
    for (int i = 0; i < 16; i++) begin
      newp = $urandom;
      @(posedge clk); #1; gpio_in = newp;
      repeat (6) @(posedge clk);
      m_stat = m_stat | (newp & ~oldp & m_rise) | (~newp & oldp & m_fall);
      oldp = newp;
      rd(8'h04, r);
      chk($sformatf("rnd_data_in_%0d", i), r, newp);
      rd(8'h24, r);
      chk($sformatf("rnd_status_%0d", i), r, m_stat);
      chk($sformatf("rnd_irq_%0d", i), {31'b0, irq}, {31'b0, |(m_stat & m_en)});
      if (i % 4 == 3) begin
        msk = $urandom;
        wr(8'h24, msk);
        m_stat = m_stat & ~msk;
        chk($sformatf("rnd_w1c_irq_%0d", i), {31'b0, irq}, {31'b0, |(m_stat & m_en)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Second-generation GPIO peripheral on the SoC Wishbone bus. Provides NUM_GPIOS bidirectional pins with atomic set/clear/toggle, per-pin rising/falling-edge interrupt capture, a shared programmable debounce filter and a single level interrupt to the core's interrupt input. Replaces the first-generation GPIO at the same base slot (0x00020400).

## Interface
- ADDR_WIDTH, 8: Wishbone byte-address width; decode uses wb_addr[5:2].
- NUM_GPIOS, 32: pin count, legal 1..32; register bits above NUM_GPIOS-1 read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser depth, legal 2..4.
- DB_WIDTH, 16: debounce prescaler width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- wb_addr  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  registered read data.
- wb_we  in  1  write strobe qualifier.
- wb_sel  in  4  byte enables; honoured on all writes.
- wb_stb  in  1  cycle strobe.
- wb_ack  out  1  one-cycle acknowledge.
- gpio_in  in  NUM_GPIOS  asynchronous pad inputs.
- gpio_out  out  NUM_GPIOS  output data (= DATA_OUT).
- gpio_oe  out  NUM_GPIOS  output enable (= DIR).
- irq  out  1  |(IRQ_STATUS & IRQ_EN).

## Operation
- Register map (offset: name, access):
  - 0x00 DATA_OUT RW; 0x04 DATA_IN RO (debounced value); 0x08 DIR RW (1=output).
  - 0x0C OUT_SET W1S; 0x10 OUT_CLR W1C; 0x14 OUT_TGL W1T. All three read as DATA_OUT.
  - 0x18 IRQ_EN RW; 0x1C IRQ_RISE RW; 0x20 IRQ_FALL RW; 0x24 IRQ_STATUS R/W1C.
  - 0x28 DB_DIV RW, DB_WIDTH bits zero-extended; 0 = debounce bypass.
  - Other offsets: read 0, writes ignored, still acked.
- Byte-masked writes: only bytes with wb_sel set change; for W1S/W1C/W1T/status-clear, unselected bytes act as 0.
- Input path: SYNC_STAGES flops → debounce → DATA_IN.
- Debounce: counter counts 0..DB_DIV, emitting a tick on wrap. On each tick, sample the synchronised inputs; a pin's filtered value updates only when two consecutive tick samples agree. DB_DIV=0: filtered value = synchronised value every cycle. Writing DB_DIV resets the counter to 0.
- Edge detect on the filtered value vs. its previous value: rise & IRQ_RISE, or fall & IRQ_FALL, sets the IRQ_STATUS bit regardless of IRQ_EN.
- Simultaneous status set and W1C on the same bit: set wins.
- Reset values: all registers 0, wb_dat_o=0, wb_ack=0, gpio_out=0, gpio_oe=0, irq=0; synchroniser/filter state 0 (no edge reported out of reset for pins low at reset).

## Timing
- Bus: wb_ack <= wb_stb && !wb_ack; access is performed in the cycle wb_stb && !wb_ack; wb_ack high exactly one cycle; wb_dat_o valid with wb_ack. No back-to-back ack; minimum 2 cycles per access.
- Write effect visible on gpio_out/gpio_oe the cycle after the access cycle (with wb_ack).
- Input latency, DB_DIV=0: pad change → DATA_IN after SYNC_STAGES+1 cycles; IRQ_STATUS and irq set 1 cycle after DATA_IN changes.
- DB_DIV=N: pad change must be stable across two ticks; worst-case filtered update ≤ 2(N+1) cycles after synchroniser output.
- irq derived combinationally from registered status/enable: glitch-free; drops the cycle after the clearing write's access cycle.
- Async reset mid-access: ack and pending write are dropped; all state returns to reset values.

## Structure
- Shared package gpio_pkg: register offset constants, DB_WIDTH default, reset-value constants.
- One sub-module gpio_debounce (synchroniser + prescaler + per-pin two-sample filter, output filtered vector and per-pin rise/fall pulses); the top holds the register file, bus logic and irq.

## Test plan
- Reset → all outputs 0; read every register → 0; access 0x3C → ack, data 0.
- Write DATA_OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30, OUT_TGL=0x101 → DATA_OUT reads 0x0000_01CE; write DIR=0xFF with wb_sel=4'b0001 over 0xFFFF_FFFF → DIR=0xFF.
- DB_DIV=0, IRQ_RISE[3]=1, IRQ_EN[3]=1; gpio_in[3] 0→1 → status bit 3 at SYNC_STAGES+2 cycles, irq=1; W1C 0x8 → irq 0 next cycle.
- IRQ_FALL[5]=1, IRQ_EN=0; pulse pin 5 high then low → status[5]=1, irq=0; set IRQ_EN[5] → irq=1.
- DB_DIV=9; 5-cycle glitch on pin 0 → DATA_IN unchanged, no status; hold 40 cycles → DATA_IN[0]=1 within 20 cycles of sync output.
- Edge on pin 2 coincident with W1C of bit 2 → status[2] remains 1; assert rst_n low mid-write → write lost, all outputs 0.
